// File: rtl/regfile_plot.sv
// 32-entry architectural register file with $r0 tied to zero, write-first bypass,
// a read-only plotter status view and a write-forwarded plot-command register.
module regfile_plot #(
   parameter int WIDTH    = 32,
   parameter int CMD_REG  = 29,
   parameter int STAT_REG = 27
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_writeEnable,
   input  logic [4:0]       ctrl_writeReg,
   input  logic [WIDTH-1:0] data_writeReg,
   input  logic [4:0]       ctrl_readRegA,
   input  logic [4:0]       ctrl_readRegB,
   output logic [WIDTH-1:0] data_readRegA,
   output logic [WIDTH-1:0] data_readRegB,
   input  logic [WIDTH-1:0] plot_status,
   output logic             cmd_valid,
   output logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_ready,
   output logic             cmd_overflow
);

   localparam logic [4:0] CMD_IDX  = 5'(CMD_REG);
   localparam logic [4:0] STAT_IDX = 5'(STAT_REG);

   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic             cmd_valid_q, cmd_valid_d;
   logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
   logic             cmd_overflow_q, cmd_overflow_d;

   logic write_ok;
   logic cmd_write;
   logic cmd_accept;

   assign write_ok   = ctrl_writeEnable && (ctrl_writeReg != 5'd0) && (ctrl_writeReg != STAT_IDX);
   assign cmd_write  = write_ok && (ctrl_writeReg == CMD_IDX);
   assign cmd_accept = cmd_valid_q && cmd_ready;

   always_comb begin
      regs_d = regs_q;
      if (write_ok) begin
         regs_d[ctrl_writeReg] = data_writeReg;
      end
   end

   // Handshake: cmd_data is transferred on an edge where cmd_valid && cmd_ready;
   // while cmd_valid is high and cmd_ready low, cmd_valid/cmd_data hold. A new
   // write replaces a pending word; it counts as overflow only if that word was
   // not accepted on the same edge.
   always_comb begin
      cmd_valid_d    = cmd_valid_q;
      cmd_data_d     = cmd_data_q;
      cmd_overflow_d = cmd_overflow_q;
      if (cmd_write) begin
         cmd_valid_d = 1'b1;
         cmd_data_d  = data_writeReg;
         if (cmd_valid_q && !cmd_ready) begin
            cmd_overflow_d = 1'b1;
         end
      end else if (cmd_accept) begin
         cmd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         cmd_valid_q    <= 1'b0;
         cmd_data_q     <= '0;
         cmd_overflow_q <= 1'b0;
      end else begin
         regs_q         <= regs_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_data_q     <= cmd_data_d;
         cmd_overflow_q <= cmd_overflow_d;
      end
   end

   // Read priority: zero register, live status, same-cycle write bypass, stored value.
   always_comb begin
      data_readRegA = regs_q[ctrl_readRegA];
      if (ctrl_readRegA == 5'd0) begin
         data_readRegA = '0;
      end else if (ctrl_readRegA == STAT_IDX) begin
         data_readRegA = plot_status;
      end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) begin
         data_readRegA = data_writeReg;
      end
   end

   always_comb begin
      data_readRegB = regs_q[ctrl_readRegB];
      if (ctrl_readRegB == 5'd0) begin
         data_readRegB = '0;
      end else if (ctrl_readRegB == STAT_IDX) begin
         data_readRegB = plot_status;
      end else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) begin
         data_readRegB = data_writeReg;
      end
   end

   assign cmd_valid    = cmd_valid_q;
   assign cmd_data     = cmd_data_q;
   assign cmd_overflow = cmd_overflow_q;

endmodule

// File: tb/tb_regfile_plot.sv
// Bench for regfile_plot: directed scenarios plus randomized traffic checked
// against a register-array / command-queue reference model.
module tb_regfile_plot;

   logic        clock;
   logic        reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic [31:0] plot_status;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        cmd_ready;
   logic        cmd_overflow;

   int tests_run = 0;
   int tests_failed = 0;

   regfile_plot dut (
      .clock            (clock),
      .reset            (reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .plot_status      (plot_status),
      .cmd_valid        (cmd_valid),
      .cmd_data         (cmd_data),
      .cmd_ready        (cmd_ready),
      .cmd_overflow     (cmd_overflow)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference model: architectural registers plus the queue of undelivered commands
   logic [31:0] m_regs [32];
   logic [31:0] exp_q [$];
   logic        m_ovf;

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (idx == 5'd27) return plot_status;
      if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
      return m_regs[idx];
   endfunction

   task automatic model_edge();
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         exp_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (cmd_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (ctrl_writeEnable && ctrl_writeReg != 5'd0 && ctrl_writeReg != 5'd27) begin
            m_regs[ctrl_writeReg] = data_writeReg;
            if (ctrl_writeReg == 5'd29) begin
               if (exp_q.size() > 0) begin
                  m_ovf = 1'b1;
                  exp_q.delete();
               end
               exp_q.push_back(data_writeReg);
            end
         end
      end
   endtask

   // driver: one clock, model follows the edge, inputs change on the falling edge
   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic drive_idle();
      reset = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg = 5'd0;
      data_writeReg = 32'h0;
      cmd_ready = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = idx;
      data_writeReg = val;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_write(5'd5, 32'hDEADBEEF);
      tick();
      ctrl_writeEnable = 1'b0;
      ctrl_readRegA = 5'd5;
      #1;
      tests_run++;
      if (data_readRegA !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL pre_reset_r5 got %h want %h", data_readRegA, 32'hDEADBEEF);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests_run++;
      if (data_readRegA !== 32'h0 || cmd_valid !== 1'b0 || cmd_overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state got r5=%h v=%b o=%b want 0 0 0", data_readRegA, cmd_valid, cmd_overflow);
      end
   endtask

   task automatic test_r0_bypass();
      do_write(5'd0, 32'h1234);
      ctrl_readRegA = 5'd0;
      #1;
      tests_run++;
      if (data_readRegA !== 32'h0) begin
         tests_failed++;
         $display("FAIL r0_during_write got %h want 0", data_readRegA);
      end
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      tests_run++;
      if (data_readRegA !== 32'h0) begin
         tests_failed++;
         $display("FAIL r0_after_write got %h want 0", data_readRegA);
      end
      do_write(5'd7, 32'hA5A5A5A5);
      ctrl_readRegB = 5'd7;
      #1;
      tests_run++;
      if (data_readRegB !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL bypass_b got %h want %h", data_readRegB, 32'hA5A5A5A5);
      end
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      tests_run++;
      if (data_readRegB !== 32'hA5A5A5A5) begin
         tests_failed++;
         $display("FAIL stored_b got %h want %h", data_readRegB, 32'hA5A5A5A5);
      end
   endtask

   task automatic test_status();
      plot_status = 32'h0000_00F0;
      ctrl_readRegA = 5'd27;
      #1;
      tests_run++;
      if (data_readRegA !== 32'hF0) begin
         tests_failed++;
         $display("FAIL status_read got %h want %h", data_readRegA, 32'hF0);
      end
      do_write(5'd27, 32'h55);
      #1;
      tests_run++;
      if (data_readRegA !== 32'hF0) begin
         tests_failed++;
         $display("FAIL status_no_bypass got %h want %h", data_readRegA, 32'hF0);
      end
      tick();
      ctrl_writeEnable = 1'b0;
      plot_status = 32'h1;
      #1;
      tests_run++;
      if (data_readRegA !== 32'h1) begin
         tests_failed++;
         $display("FAIL status_live got %h want %h", data_readRegA, 32'h1);
      end
   endtask

   task automatic test_handshake();
      cmd_ready = 1'b0;
      do_write(5'd29, 32'h00010002);
      tick();
      ctrl_writeEnable = 1'b0;
      ctrl_readRegA = 5'd29;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (cmd_valid !== 1'b1 || cmd_data !== 32'h00010002 || data_readRegA !== 32'h00010002) begin
            tests_failed++;
            $display("FAIL hold_cycle%0d got v=%b d=%h r29=%h want 1 %h %h", c, cmd_valid, cmd_data,
                     data_readRegA, 32'h00010002, 32'h00010002);
         end
         tick();
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      #1;
      tests_run++;
      if (cmd_valid !== 1'b0 || data_readRegA !== 32'h00010002) begin
         tests_failed++;
         $display("FAIL accept got v=%b r29=%h want 0 %h", cmd_valid, data_readRegA, 32'h00010002);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      cmd_ready = 1'b0;
      do_write(5'd29, 32'h1);
      tick();
      do_write(5'd29, 32'h2);
      tick();
      ctrl_writeEnable = 1'b0;
      #1;
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_data !== 32'h2 || cmd_overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow got v=%b d=%h o=%b want 1 2 1", cmd_valid, cmd_data, cmd_overflow);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      #1;
      tests_run++;
      if (cmd_overflow !== 1'b1 || cmd_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_sticky got o=%b v=%b want 1 0", cmd_overflow, cmd_valid);
      end
   endtask

   task automatic test_accept_write();
      do_reset();
      cmd_ready = 1'b0;
      do_write(5'd29, 32'h9);
      tick();
      do_write(5'd29, 32'h3);
      cmd_ready = 1'b1;
      tick();
      ctrl_writeEnable = 1'b0;
      cmd_ready = 1'b0;
      #1;
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_data !== 32'h3 || cmd_overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL accept_and_write got v=%b d=%h o=%b want 1 3 0", cmd_valid, cmd_data, cmd_overflow);
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h10;
      vals[1] = 32'h11;
      vals[2] = 32'h12;
      cmd_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         do_write(5'd29, vals[k]);
         tick();
         ctrl_writeEnable = 1'b0;
         #1;
         tests_run++;
         if (cmd_valid !== 1'b1 || cmd_data !== vals[k]) begin
            tests_failed++;
            $display("FAIL b2b_%0d got v=%b d=%h want 1 %h", k, cmd_valid, cmd_data, vals[k]);
         end
      end
      tick();
      #1;
      tests_run++;
      if (cmd_valid !== 1'b0 || cmd_overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_drain got v=%b o=%b want 0 0", cmd_valid, cmd_overflow);
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset_pending();
      cmd_ready = 1'b0;
      do_write(5'd29, 32'hCAFE);
      tick();
      reset = 1'b1;
      do_write(5'd29, 32'h77);
      tick();
      drive_idle();
      ctrl_readRegA = 5'd29;
      #1;
      tests_run++;
      if (cmd_valid !== 1'b0 || cmd_overflow !== 1'b0 || data_readRegA !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_drops_cmd got v=%b o=%b r29=%h want 0 0 0", cmd_valid, cmd_overflow, data_readRegA);
      end
   endtask

   task automatic test_random();
      logic [4:0] idx_pool [6];
      idx_pool[0] = 5'd0;
      idx_pool[1] = 5'd27;
      idx_pool[2] = 5'd29;
      idx_pool[3] = 5'd29;
      idx_pool[4] = 5'd3;
      idx_pool[5] = 5'd31;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         ctrl_writeEnable = ($urandom_range(0, 3) != 0);
         ctrl_writeReg = ($urandom_range(0, 1) == 0) ? idx_pool[$urandom_range(0, 5)] : 5'($urandom);
         data_writeReg = $urandom;
         ctrl_readRegA = ($urandom_range(0, 2) == 0) ? ctrl_writeReg : 5'($urandom);
         ctrl_readRegB = ($urandom_range(0, 2) == 0) ? idx_pool[$urandom_range(0, 5)] : 5'($urandom);
         plot_status = $urandom;
         cmd_ready = ($urandom_range(0, 2) == 0);
         #1;
         tests_run++;
         if (data_readRegA !== model_read(ctrl_readRegA) || data_readRegB !== model_read(ctrl_readRegB)) begin
            tests_failed++;
            $display("FAIL rand_read n=%0d got A=%h B=%h want A=%h B=%h", n, data_readRegA, data_readRegB,
                     model_read(ctrl_readRegA), model_read(ctrl_readRegB));
         end
         tests_run++;
         if (cmd_valid !== (exp_q.size() != 0) || cmd_overflow !== m_ovf ||
             (exp_q.size() != 0 && cmd_data !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL rand_cmd n=%0d got v=%b d=%h o=%b want v=%b d=%h o=%b", n, cmd_valid, cmd_data,
                     cmd_overflow, exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : 32'h0, m_ovf);
         end
         tick();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      ctrl_readRegA = 5'd0;
      ctrl_readRegB = 5'd0;
      plot_status = 32'h0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      test_reset();
      test_r0_bypass();
      test_status();
      test_handshake();
      test_overflow();
      test_accept_write();
      test_back_to_back();
      test_reset_pending();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
